// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe
//   Registered Rijndael ShiftRows stage with a valid/ready handshake. The row
//   permutation is pure wiring feeding the write port of a 2-entry FIFO, so
//   stored data is already shifted and the output side has one cycle latency.
//
//   Parameters
//     NB     columns per state (4, 6 or 8); state width W = 32*NB
//     TAG_W  width of the sideband tag carried with each block
//
//   Build option
//     SHIFT_ROWS_INV_EN  when defined, in_inv_i selects InvShiftRows per block
//                        and out_inv_o echoes it. When undefined, only the
//                        forward shift is built and out_inv_o is tied to 0.
//
//   Ports
//     clk           clock, rising edge
//     rst           asynchronous active-high reset
//     flush_i       synchronous clear of buffered blocks (beats push/pop)
//     in_valid_i    input block valid
//     in_ready_o    stage can accept a block (registers only)
//     in_state_i    input state, byte k=4c+r at bits [W-1-8k -: 8]
//     in_inv_i      1 = InvShiftRows, 0 = ShiftRows
//     in_tag_i      sideband tag
//     out_valid_o   output block valid
//     out_ready_i   downstream accepts output
//     out_state_o   shifted state of the head entry
//     out_inv_o     mode the head entry was processed with
//     out_tag_o     tag of the head entry
//     busy_o        buffer non-empty

module shift_rows_pipe #(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [32*NB-1:0]    in_state_i,
    input  logic                in_inv_i,
    input  logic [TAG_W-1:0]    in_tag_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [32*NB-1:0]    out_state_o,
    output logic                out_inv_o,
    output logic [TAG_W-1:0]    out_tag_o,
    output logic                busy_o
);

    localparam int unsigned W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    // Row offsets; only NB=8 uses the wider spacing for rows 2 and 3.
    function automatic int unsigned row_shift(input int unsigned r);
        case (r)
            0:       row_shift = 0;
            1:       row_shift = 1;
            2:       row_shift = (NB == 8) ? 3 : 2;
            default: row_shift = (NB == 8) ? 4 : 3;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Permutation (wiring only)
    // ------------------------------------------------------------------
    logic [W-1:0] fwd_state;
    logic [W-1:0] shifted_state;

    for (genvar c = 0; c < NB; c++) begin : g_fwd_col
        for (genvar r = 0; r < 4; r++) begin : g_fwd_row
            localparam int unsigned Src = (c + row_shift(r)) % NB;
            assign fwd_state[W-1-8*(4*c+r) -: 8] = in_state_i[W-1-8*(4*Src+r) -: 8];
        end
    end

`ifdef SHIFT_ROWS_INV_EN
    logic [W-1:0] inv_state;

    for (genvar c = 0; c < NB; c++) begin : g_inv_col
        for (genvar r = 0; r < 4; r++) begin : g_inv_row
            localparam int unsigned Src = (c + NB - row_shift(r)) % NB;
            assign inv_state[W-1-8*(4*c+r) -: 8] = in_state_i[W-1-8*(4*Src+r) -: 8];
        end
    end

    assign shifted_state = in_inv_i ? inv_state : fwd_state;
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv_i;
    assign shifted_state = fwd_state;
`endif

    // ------------------------------------------------------------------
    // 2-entry FIFO
    // ------------------------------------------------------------------
    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [W-1:0]     state_q [2];
    logic [TAG_W-1:0] tag_q   [2];
    logic             push;
    logic             pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign busy_o      = out_valid_o;

    // Storage only written on an accepted push, so X on idle inputs never reaches outputs.
    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i & ~flush_i;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push) begin
                state_q[wr_ptr_q] <= shifted_state;
                tag_q[wr_ptr_q]   <= in_tag_i;
            end
        end
    end

    assign out_state_o = state_q[rd_ptr_q];
    assign out_tag_o   = tag_q[rd_ptr_q];

`ifdef SHIFT_ROWS_INV_EN
    logic inv_q [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q[0] <= 1'b0;
            inv_q[1] <= 1'b0;
        end else if (push) begin
            inv_q[wr_ptr_q] <= in_inv_i;
        end
    end

    assign out_inv_o = inv_q[rd_ptr_q];
`else
    assign out_inv_o = 1'b0;
`endif

endmodule

// File: tb/tb_shift_rows_pipe.sv
module tb_shift_rows_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // NB=4 instance
    logic         flush, in_valid, in_ready, in_inv, out_valid, out_ready, out_inv, busy;
    logic [127:0] in_state, out_state;
    logic [3:0]   in_tag, out_tag;

    shift_rows_pipe #(.NB(4), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_state_i(in_state),
        .in_inv_i(in_inv), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_state_o(out_state),
        .out_inv_o(out_inv), .out_tag_o(out_tag), .busy_o(busy)
    );

    // NB=8 instance
    logic         flush8, in_valid8, in_ready8, in_inv8, out_valid8, out_ready8, out_inv8, busy8;
    logic [255:0] in_state8, out_state8;
    logic [3:0]   in_tag8, out_tag8;

    shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst(rst), .flush_i(flush8),
        .in_valid_i(in_valid8), .in_ready_o(in_ready8), .in_state_i(in_state8),
        .in_inv_i(in_inv8), .in_tag_i(in_tag8),
        .out_valid_o(out_valid8), .out_ready_i(out_ready8), .out_state_o(out_state8),
        .out_inv_o(out_inv8), .out_tag_o(out_tag8), .busy_o(busy8)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

`ifdef SHIFT_ROWS_INV_EN
    localparam bit InvEn = 1'b1;
`else
    localparam bit InvEn = 1'b0;
`endif

    // Reference: treat the state as a 4 x nb byte matrix and rotate each row.
    function automatic logic [255:0] model_shift(input logic [255:0] s, input int nb,
                                                 input bit inv);
        logic [7:0] m [4][8];
        logic [255:0] o;
        int w, sh, src;
        w = 32 * nb;
        o = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) m[r][c] = s[w-1-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++) begin
            sh = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? (nb == 8 ? 3 : 2) : (nb == 8 ? 4 : 3);
            for (int c = 0; c < nb; c++) begin
                src = inv ? (c - sh + nb) % nb : (c + sh) % nb;
                o[w-1-8*(4*c+r) -: 8] = m[r][src];
            end
        end
        return o;
    endfunction

    typedef struct {
        logic [127:0] st;
        logic         inv;
        logic [3:0]   tag;
        logic [127:0] exp;
        logic         exp_inv;
    } vec_t;

    vec_t tbl [5];

    typedef struct {
        logic [127:0] st;
        logic         inv;
        logic [3:0]   tag;
    } ent_t;

    ent_t q [$];

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_state = 'x;
        in_inv   = 1'b0;
        in_tag   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [255:0] b8;
        logic [255:0] e8;
        logic         push_m, pop_m, fl;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        idle_inputs();
        flush8 = 1'b0; in_valid8 = 1'b0; in_state8 = '0; in_inv8 = 1'b0; in_tag8 = '0;
        out_ready8 = 1'b1;

        tbl[0] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'h1,
                   128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0};
        tbl[1] = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 4'h2,
                   InvEn ? 128'hd42711aee0bf98f1b8b45de51e415230
                         : 128'hd4b411e5e0419830b8275dae1ebf52f1, InvEn};
        tbl[2] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b0, 4'h3,
                   128'h00050a0f04090e03080d02070c01060b, 1'b0};
        tbl[3] = '{128'h000102030405060708090a0b0c0d0e0f, 1'b1, 4'hf,
                   InvEn ? 128'h000d0a0704010e0b0805020f0c090603
                         : 128'h00050a0f04090e03080d02070c01060b, InvEn};
        // Each row constant: any rotation leaves it unchanged.
        tbl[4] = '{128'h00112233001122330011223300112233, 1'b1, 4'h8,
                   128'h00112233001122330011223300112233, InvEn};

        do_reset();
        check("rst_out_valid", 256'(out_valid), 256'd0);
        check("rst_busy",      256'(busy),      256'd0);
        check("rst_in_ready",  256'(in_ready),  256'd1);
        check("rst_out_state", 256'(out_state), 256'd0);
        check("rst_out_tag",   256'(out_tag),   256'd0);
        check("rst_out_inv",   256'(out_inv),   256'd0);

        // Table vectors: one block each, 1-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_state = tbl[i].st; in_inv = tbl[i].inv; in_tag = tbl[i].tag;
            @(posedge clk);
            #1 idle_inputs();
            check($sformatf("tbl%0d_valid", i), 256'(out_valid), 256'd1);
            check($sformatf("tbl%0d_state", i), 256'(out_state), 256'(tbl[i].exp));
            check($sformatf("tbl%0d_inv", i),   256'(out_inv),   256'(tbl[i].exp_inv));
            check($sformatf("tbl%0d_tag", i),   256'(out_tag),   256'(tbl[i].tag));
            @(posedge clk);
            #1;
        end
        check("tbl_drained", 256'(out_valid), 256'd0);

        // NB=8: bytes 00..1f; offsets 0,1,3,4.
        for (int k = 0; k < 32; k++) b8[255-8*k -: 8] = 8'(k);
        in_valid8 = 1'b1; in_state8 = b8; in_tag8 = 4'h5;
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        check("nb8_valid", 256'(out_valid8), 256'd1);
        check("nb8_word0", 256'(out_state8[255 -: 32]), 256'(32'h00050e13));
        check("nb8_word7", 256'(out_state8[31:0]),      256'(32'h1c010a0f));
        check("nb8_full",  out_state8, model_shift(b8, 8, 1'b0));
        for (int i = 0; i < 4; i++) begin
            e8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            in_valid8 = 1'b1; in_state8 = e8; in_inv8 = 1'($urandom); in_tag8 = 4'(i);
            @(posedge clk);
            #1 in_valid8 = 1'b0;
            check($sformatf("nb8_rand%0d", i), out_state8, model_shift(e8, 8, in_inv8 & InvEn));
            check($sformatf("nb8_rinv%0d", i), 256'(out_inv8), 256'(in_inv8 & InvEn));
        end
        @(posedge clk);
        #1;

        // Back-pressure: two pushes fill the buffer.
        out_ready = 1'b0;
        in_valid = 1'b1; in_state = '0; in_tag = 4'h1;
        @(posedge clk);
        #1 in_tag = 4'h2;
        check("bp_ready_after1", 256'(in_ready), 256'd1);
        @(posedge clk);
        #1 idle_inputs();
        check("bp_ready_full", 256'(in_ready), 256'd0);
        check("bp_head1",      256'(out_tag),  256'h1);
        @(posedge clk);
        #1;
        check("bp_hold_tag",   256'(out_tag),  256'h1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready_after_pop", 256'(in_ready), 256'd1);
        check("bp_head2",           256'(out_tag),  256'h2);
        check("bp_valid2",          256'(out_valid), 256'd1);
        @(posedge clk);
        #1;
        check("bp_empty", 256'(out_valid), 256'd0);

        // Streaming at count=1 for 8 cycles.
        out_ready = 1'b0;
        in_valid = 1'b1; in_state = '0; in_tag = 4'h0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_tag = 4'(i);
            @(negedge clk);
            check($sformatf("st%0d_valid", i), 256'(out_valid), 256'd1);
            check($sformatf("st%0d_ready", i), 256'(in_ready),  256'd1);
            check($sformatf("st%0d_tag", i),   256'(out_tag),   256'(4'(i - 1)));
            @(posedge clk);
            #1;
        end
        idle_inputs();
        check("st_last_tag", 256'(out_tag), 256'h8);
        @(posedge clk);
        #1;
        check("st_drained", 256'(out_valid), 256'd0);

        // Flush at count=2 with a coincident push.
        out_ready = 1'b0;
        in_valid = 1'b1; in_state = '0; in_tag = 4'h3;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 flush = 1'b1; in_tag = 4'h4;
        @(posedge clk);
        #1 flush = 1'b0; idle_inputs();
        check("fl_valid", 256'(out_valid), 256'd0);
        check("fl_busy",  256'(busy),      256'd0);
        check("fl_ready", 256'(in_ready),  256'd1);

        // Flush with count=1 and a push on the same edge: push discarded.
        in_valid = 1'b1; in_tag = 4'h6;
        @(posedge clk);
        #1 flush = 1'b1; in_tag = 4'h7;
        @(posedge clk);
        #1 flush = 1'b0; idle_inputs();
        check("fl2_valid", 256'(out_valid), 256'd0);

        // Reset mid-stream.
        in_valid = 1'b1; in_state = 128'hdeadbeef; in_tag = 4'h9;
        @(posedge clk);
        #1 idle_inputs();
        check("rs_pre_valid", 256'(out_valid), 256'd1);
        #2 rst = 1'b1;
        #1;
        check("rs_async_valid", 256'(out_valid), 256'd0);
        check("rs_async_state", 256'(out_state), 256'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rs_ready", 256'(in_ready),  256'd1);
        check("rs_valid", 256'(out_valid), 256'd0);
        check("rs_tag",   256'(out_tag),   256'd0);

        // Random traffic against a queue model.
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            fl        = ($urandom_range(0, 19) == 0);
            flush     = fl;
            in_valid  = 1'($urandom);
            in_state  = {$urandom, $urandom, $urandom, $urandom};
            in_inv    = 1'($urandom);
            in_tag    = 4'($urandom);
            out_ready = 1'($urandom);
            @(negedge clk);
            check("rnd_in_ready",  256'(in_ready),  256'(q.size() != 2));
            check("rnd_out_valid", 256'(out_valid), 256'(q.size() != 0));
            check("rnd_busy",      256'(busy),      256'(q.size() != 0));
            if (q.size() != 0) begin
                check("rnd_state", 256'(out_state), model_shift(256'(q[0].st), 4, q[0].inv & InvEn));
                check("rnd_inv",   256'(out_inv),   256'(q[0].inv & InvEn));
                check("rnd_tag",   256'(out_tag),   256'(q[0].tag));
            end
            push_m = in_valid && (q.size() < 2) && !fl;
            pop_m  = out_ready && (q.size() > 0) && !fl;
            @(posedge clk);
            if (fl) q.delete();
            else begin
                if (pop_m)  void'(q.pop_front());
                if (push_m) q.push_back('{in_state, in_inv, in_tag});
            end
            #1;
        end
        flush = 1'b0;
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
